// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: ALU opcodes, RegDest selects, register numbers
// and the control bundle that the ID/EX register carries.
package pipeline_pkg;

   localparam logic [4:0] ALUOP_NOP  = 5'b00000;
   localparam logic [4:0] ALUOP_MULT = 5'b01100;

   typedef enum logic [1:0] {
      REGDEST_RD   = 2'b00,
      REGDEST_RT   = 2'b01,
      REGDEST_RA   = 2'b10,
      REGDEST_NONE = 2'b11
   } regdest_e;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       mem_read;
      logic       jal;
      logic [1:0] mem_to_reg;
      logic [1:0] byte_sel;
      logic [4:0] alu_op;
   } ctrl_t;

   // A bubble has no architectural side effects and decodes as a NOP.
   localparam ctrl_t BUBBLE_CTRL = '{
      reg_write:  1'b0,
      alu_src:    1'b0,
      mem_write:  1'b0,
      mem_read:   1'b0,
      jal:        1'b0,
      mem_to_reg: 2'b00,
      byte_sel:   2'b00,
      alu_op:     ALUOP_NOP
   };

endpackage

// File: rtl/id_ex_stage_register_load_use_detector.sv
// Flags a decode-stage instruction that reads the destination of a load
// currently sitting in EX; writes to r0 never create a hazard.
module load_use_detector
   import pipeline_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic       ex_reg_write,
   input  logic [4:0] ex_write_reg,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   output logic       load_use
);

   always_comb begin
      load_use = ex_mem_read && ex_reg_write && (ex_write_reg != REG_ZERO) &&
                 ((ex_write_reg == rs) || (ex_write_reg == rt));
   end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with destination resolution, load-use bubbling and
// upstream stall enables. Define MULT_STALL_EN to hold EX for multi-cycle multiplies.
module id_ex_stage_register
   import pipeline_pkg::*;
#(
   parameter int unsigned MULT_LATENCY = 4
)
(
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [1:0]  RegDest,
   input  logic        RegWrite,
   input  logic        AluSrc,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic        JAL,
   input  logic [1:0]  MemToReg,
   input  logic [1:0]  ByteSel,
   input  logic [4:0]  AluOp,
   input  logic [31:0] ReadData1,
   input  logic [31:0] ReadData2,
   input  logic [31:0] Immediate,
   input  logic [31:0] PCPlus4,
   input  logic [4:0]  Rs,
   input  logic [4:0]  Rt,
   input  logic [4:0]  Rd,
   input  logic        Flush,
   output logic        ExRegWrite,
   output logic        ExAluSrc,
   output logic        ExMemWrite,
   output logic        ExMemRead,
   output logic        ExJAL,
   output logic [1:0]  ExMemToReg,
   output logic [1:0]  ExByteSel,
   output logic [4:0]  ExAluOp,
   output logic [31:0] ExReadData1,
   output logic [31:0] ExReadData2,
   output logic [31:0] ExImmediate,
   output logic [31:0] ExPCPlus4,
   output logic [4:0]  ExRs,
   output logic [4:0]  ExRt,
   output logic [4:0]  ExWriteReg,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        ExHold
);

   // Empty marker block: shows up in the hierarchy when configured out of range.
   if (MULT_LATENCY < 2 || MULT_LATENCY > 15) begin : g_illegal_mult_latency
   end

   ctrl_t      dec_ctrl;
   ctrl_t      ex_ctrl;
   logic [4:0] dec_write_reg;
   logic       load_use;
   logic       bubble;
   logic       hold;

   always_comb begin
      dec_ctrl = '{
         reg_write:  RegWrite,
         alu_src:    AluSrc,
         mem_write:  MemWrite,
         mem_read:   MemRead,
         jal:        JAL,
         mem_to_reg: MemToReg,
         byte_sel:   ByteSel,
         alu_op:     AluOp
      };
   end

   always_comb begin
      dec_write_reg = REG_ZERO;
      case (regdest_e'(RegDest))
         REGDEST_RD:   dec_write_reg = Rd;
         REGDEST_RT:   dec_write_reg = Rt;
         REGDEST_RA:   dec_write_reg = REG_RA;
         REGDEST_NONE: dec_write_reg = REG_ZERO;
         default:      dec_write_reg = REG_ZERO;
      endcase
   end

   load_use_detector u_load_use_detector (
      .ex_mem_read  (ex_ctrl.mem_read),
      .ex_reg_write (ex_ctrl.reg_write),
      .ex_write_reg (ExWriteReg),
      .rs           (Rs),
      .rt           (Rt),
      .load_use     (load_use)
   );

   assign bubble = Flush | load_use;

`ifdef MULT_STALL_EN
   typedef enum logic {RUN, MULT_WAIT} state_e;

   localparam logic [3:0] MULT_CNT_LOAD = 4'(MULT_LATENCY - 1);

   state_e     state;
   logic [3:0] mult_cnt;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= RUN;
         mult_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!bubble && (AluOp == ALUOP_MULT)) begin
                  state    <= MULT_WAIT;
                  mult_cnt <= MULT_CNT_LOAD;
               end
            end
            MULT_WAIT: begin
               if (mult_cnt <= 4'd1) begin
                  state    <= RUN;
                  mult_cnt <= '0;
               end else begin
                  mult_cnt <= mult_cnt - 4'd1;
               end
            end
            default: begin
               state    <= RUN;
               mult_cnt <= '0;
            end
         endcase
      end
   end

   assign hold = (state == MULT_WAIT);
`else
   assign hold = 1'b0;
`endif

   assign ExHold = hold;

   // Data and specifiers are captured even on a bubble; only control is killed.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         ex_ctrl     <= '0;
         ExWriteReg  <= '0;
         ExReadData1 <= '0;
         ExReadData2 <= '0;
         ExImmediate <= '0;
         ExPCPlus4   <= '0;
         ExRs        <= '0;
         ExRt        <= '0;
      end else if (!hold) begin
         ExReadData1 <= ReadData1;
         ExReadData2 <= ReadData2;
         ExImmediate <= Immediate;
         ExPCPlus4   <= PCPlus4;
         ExRs        <= Rs;
         ExRt        <= Rt;
         if (bubble) begin
            ex_ctrl    <= BUBBLE_CTRL;
            ExWriteReg <= REG_ZERO;
         end else begin
            ex_ctrl    <= dec_ctrl;
            ExWriteReg <= dec_write_reg;
         end
      end
   end

   assign ExRegWrite = ex_ctrl.reg_write;
   assign ExAluSrc   = ex_ctrl.alu_src;
   assign ExMemWrite = ex_ctrl.mem_write;
   assign ExMemRead  = ex_ctrl.mem_read;
   assign ExJAL      = ex_ctrl.jal;
   assign ExMemToReg = ex_ctrl.mem_to_reg;
   assign ExByteSel  = ex_ctrl.byte_sel;
   assign ExAluOp    = ex_ctrl.alu_op;

   // A flush must let the redirect through even when a load-use is also seen.
   always_comb begin
      PCWrite = 1'b1;
      if (hold || (!Flush && load_use)) begin
         PCWrite = 1'b0;
      end
   end

   assign IFIDWrite = PCWrite;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Scoreboard bench for id_ex_stage_register; multiply-hold scenarios run
// only when MULT_STALL_EN is defined.
module tb_id_ex_stage_register;

   localparam int unsigned MULT_LATENCY = 4;

   logic        Clock, Reset_n;
   logic [1:0]  RegDest;
   logic        RegWrite, AluSrc, MemWrite, MemRead, JAL;
   logic [1:0]  MemToReg, ByteSel;
   logic [4:0]  AluOp;
   logic [31:0] ReadData1, ReadData2, Immediate, PCPlus4;
   logic [4:0]  Rs, Rt, Rd;
   logic        Flush;
   logic        ExRegWrite, ExAluSrc, ExMemWrite, ExMemRead, ExJAL;
   logic [1:0]  ExMemToReg, ExByteSel;
   logic [4:0]  ExAluOp;
   logic [31:0] ExReadData1, ExReadData2, ExImmediate, ExPCPlus4;
   logic [4:0]  ExRs, ExRt, ExWriteReg;
   logic        PCWrite, IFIDWrite, ExHold;

   id_ex_stage_register #(.MULT_LATENCY(MULT_LATENCY)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .RegDest(RegDest),
      .RegWrite(RegWrite), .AluSrc(AluSrc), .MemWrite(MemWrite), .MemRead(MemRead), .JAL(JAL),
      .MemToReg(MemToReg), .ByteSel(ByteSel), .AluOp(AluOp),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .Immediate(Immediate), .PCPlus4(PCPlus4),
      .Rs(Rs), .Rt(Rt), .Rd(Rd), .Flush(Flush),
      .ExRegWrite(ExRegWrite), .ExAluSrc(ExAluSrc), .ExMemWrite(ExMemWrite), .ExMemRead(ExMemRead),
      .ExJAL(ExJAL), .ExMemToReg(ExMemToReg), .ExByteSel(ExByteSel), .ExAluOp(ExAluOp),
      .ExReadData1(ExReadData1), .ExReadData2(ExReadData2), .ExImmediate(ExImmediate),
      .ExPCPlus4(ExPCPlus4), .ExRs(ExRs), .ExRt(ExRt), .ExWriteReg(ExWriteReg),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .ExHold(ExHold)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [1:0]  regdest;
      logic        rw, asrc, mw, mr, jal;
      logic [1:0]  m2r, bsel;
      logic [4:0]  aluop;
      logic [31:0] rd1, rd2, imm, pc4;
      logic [4:0]  rs, rt, rd;
      logic        flush;
   } in_t;

   typedef struct packed {
      logic        rw, asrc, mw, mr, jal;
      logic [1:0]  m2r, bsel;
      logic [4:0]  aluop;
      logic [31:0] rd1, rd2, imm, pc4;
      logic [4:0]  rs, rt, wr;
   } exp_t;

   exp_t sbq[$];
   exp_t model;
   int   m_hold;
   logic m_pc_exp;
   int   pass_cnt, total_cnt;

   function automatic in_t mk(input logic [1:0] rdst, input logic rw, input logic asrc,
                              input logic mw, input logic mr, input logic jal,
                              input logic [1:0] m2r, input logic [1:0] bsel, input logic [4:0] aop,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] imm);
      in_t s;
      s.regdest = rdst; s.rw = rw; s.asrc = asrc; s.mw = mw; s.mr = mr; s.jal = jal;
      s.m2r = m2r; s.bsel = bsel; s.aluop = aop;
      s.rd1 = $urandom; s.rd2 = $urandom; s.imm = imm; s.pc4 = $urandom & 32'hFFFF_FFFC;
      s.rs = rs; s.rt = rt; s.rd = rd; s.flush = 1'b0;
      return s;
   endfunction

   function automatic in_t i_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
      return mk(2'b01, 1, 1, 0, 0, 0, 2'b00, 2'b00, 5'b00001, rs, rt, 5'd0, imm);
   endfunction
   function automatic in_t i_lw(input logic [4:0] rs, input logic [4:0] rt);
      return mk(2'b01, 1, 1, 0, 1, 0, 2'b01, 2'b11, 5'b00001, rs, rt, 5'd0, 32'd4);
   endfunction
   function automatic in_t i_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return mk(2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5'b00010, rs, rt, rd, 32'd0);
   endfunction
   function automatic in_t i_jal();
      return mk(2'b10, 1, 0, 0, 0, 1, 2'b10, 2'b00, 5'b00000, 5'd0, 5'd0, 5'd0, 32'h0000_0400);
   endfunction
   function automatic in_t i_mul(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return mk(2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5'b01100, rs, rt, rd, 32'd0);
   endfunction

   function automatic exp_t sample();
      exp_t g;
      g.rw = ExRegWrite; g.asrc = ExAluSrc; g.mw = ExMemWrite; g.mr = ExMemRead; g.jal = ExJAL;
      g.m2r = ExMemToReg; g.bsel = ExByteSel; g.aluop = ExAluOp;
      g.rd1 = ExReadData1; g.rd2 = ExReadData2; g.imm = ExImmediate; g.pc4 = ExPCPlus4;
      g.rs = ExRs; g.rt = ExRt; g.wr = ExWriteReg;
      return g;
   endfunction

   function automatic exp_t pop_exp();
      if (sbq.size() == 0) return 'x;
      return sbq.pop_front();
   endfunction

   // Drive one decode-stage instruction and record what EX must hold after the edge.
   task automatic apply(input in_t s);
      exp_t n;
      logic lu, kill;
      RegDest = s.regdest; RegWrite = s.rw; AluSrc = s.asrc; MemWrite = s.mw; MemRead = s.mr;
      JAL = s.jal; MemToReg = s.m2r; ByteSel = s.bsel; AluOp = s.aluop;
      ReadData1 = s.rd1; ReadData2 = s.rd2; Immediate = s.imm; PCPlus4 = s.pc4;
      Rs = s.rs; Rt = s.rt; Rd = s.rd; Flush = s.flush;
      if (m_hold > 0) begin
         n = model;
         m_hold--;
         m_pc_exp = 1'b0;
      end else begin
         lu = model.mr && model.rw && (model.wr != 5'd0) && (model.wr == s.rs || model.wr == s.rt);
         kill = s.flush || lu;
         m_pc_exp = s.flush || !lu;
         n = '0;
         n.rd1 = s.rd1; n.rd2 = s.rd2; n.imm = s.imm; n.pc4 = s.pc4; n.rs = s.rs; n.rt = s.rt;
         if (!kill) begin
            n.rw = s.rw; n.asrc = s.asrc; n.mw = s.mw; n.mr = s.mr; n.jal = s.jal;
            n.m2r = s.m2r; n.bsel = s.bsel; n.aluop = s.aluop;
            case (s.regdest)
               2'b00:   n.wr = s.rd;
               2'b01:   n.wr = s.rt;
               2'b10:   n.wr = 5'd31;
               default: n.wr = 5'd0;
            endcase
`ifdef MULT_STALL_EN
            if (s.aluop == 5'b01100) m_hold = MULT_LATENCY - 1;
`endif
         end
      end
      model = n;
      sbq.push_back(n);
      #1;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic model_reset();
      model = '0;
      m_hold = 0;
      sbq.delete();
   endtask

   task automatic test_reset();
      exp_t got, want;
      Reset_n = 1'b0;
      apply(i_add(5'd0, 5'd0, 5'd0));
      model_reset();
      repeat (2) @(posedge Clock);
      #1;
      Reset_n = 1'b1;
      apply(i_addi(5'd1, 5'd2, 32'h55)); tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want) $display("FAIL pre_traffic got=%h want=%h", got, want); else pass_cnt++;
      apply(i_lw(5'd3, 5'd4));
      #2;
      Reset_n = 1'b0;
      #1;
      model_reset();
      got = sample(); total_cnt++;
      if (got !== exp_t'('0)) $display("FAIL reset_ex_zero got=%h want=0", got); else pass_cnt++;
      total_cnt++;
      if ({PCWrite, IFIDWrite, ExHold} !== 3'b110)
         $display("FAIL reset_enables got=%b want=110", {PCWrite, IFIDWrite, ExHold});
      else pass_cnt++;
      @(posedge Clock);
      #1;
      got = sample(); total_cnt++;
      if (got !== exp_t'('0)) $display("FAIL reset_held got=%h want=0", got); else pass_cnt++;
      Reset_n = 1'b1;
      apply(i_addi(5'd1, 5'd5, 32'h10)); tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want) $display("FAIL reset_release_addi got=%h want=%h", got, want); else pass_cnt++;
   endtask

   task automatic test_dest();
      exp_t got, want;
      in_t s;
      apply(i_addi(5'd1, 5'd5, 32'h10)); tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want) $display("FAIL addi_bundle got=%h want=%h", got, want); else pass_cnt++;
      total_cnt++;
      if ({ExWriteReg, ExAluSrc, ExAluOp} !== {5'd5, 1'b1, 5'b00001})
         $display("FAIL addi_fields got=%h/%b/%b want=05/1/00001", ExWriteReg, ExAluSrc, ExAluOp);
      else pass_cnt++;
      apply(i_jal()); tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want) $display("FAIL jal_bundle got=%h want=%h", got, want); else pass_cnt++;
      total_cnt++;
      if ({ExWriteReg, ExJAL} !== {5'd31, 1'b1})
         $display("FAIL jal_fields got=%0d/%b want=31/1", ExWriteReg, ExJAL);
      else pass_cnt++;
      apply(i_add(5'd6, 5'd7, 5'd12)); tick();
      total_cnt++;
      if (ExWriteReg !== 5'd12) $display("FAIL dest_rd got=%0d want=12", ExWriteReg); else pass_cnt++;
      void'(pop_exp());
      s = i_add(5'd6, 5'd7, 5'd12);
      s.regdest = 2'b11;
      apply(s); tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want || ExWriteReg !== 5'd0)
         $display("FAIL dest_none got=%h want=%h", got, want);
      else pass_cnt++;
   endtask

   task automatic test_load_use();
      exp_t got, want;
      apply(i_lw(5'd1, 5'd8)); tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want) $display("FAIL lw_bundle got=%h want=%h", got, want); else pass_cnt++;
      apply(i_add(5'd8, 5'd2, 5'd3));
      total_cnt++;
      if ({PCWrite, IFIDWrite} !== 2'b00)
         $display("FAIL lu_stall got=%b want=00", {PCWrite, IFIDWrite});
      else pass_cnt++;
      tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want || ExRegWrite !== 1'b0)
         $display("FAIL lu_bubble got=%h want=%h", got, want);
      else pass_cnt++;
      apply(i_add(5'd8, 5'd2, 5'd3));
      total_cnt++;
      if ({PCWrite, IFIDWrite} !== 2'b11)
         $display("FAIL lu_one_cycle got=%b want=11", {PCWrite, IFIDWrite});
      else pass_cnt++;
      tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want || ExWriteReg !== 5'd3)
         $display("FAIL lu_add_captured got=%h want=%h", got, want);
      else pass_cnt++;
   endtask

   task automatic test_load_use_negative();
      exp_t got, want;
      apply(i_lw(5'd1, 5'd0)); tick();
      void'(pop_exp());
      apply(i_add(5'd0, 5'd4, 5'd5));
      total_cnt++;
      if ({PCWrite, IFIDWrite} !== 2'b11)
         $display("FAIL lu_r0_nostall got=%b want=11", {PCWrite, IFIDWrite});
      else pass_cnt++;
      tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want) $display("FAIL lu_r0_capture got=%h want=%h", got, want); else pass_cnt++;
      apply(i_lw(5'd1, 5'd8)); tick();
      void'(pop_exp());
      apply(i_add(5'd9, 5'd10, 5'd11));
      total_cnt++;
      if ({PCWrite, IFIDWrite} !== 2'b11)
         $display("FAIL lu_other_regs got=%b want=11", {PCWrite, IFIDWrite});
      else pass_cnt++;
      tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want) $display("FAIL lu_other_capture got=%h want=%h", got, want); else pass_cnt++;
   endtask

   task automatic test_flush();
      exp_t got, want;
      in_t s;
      apply(i_lw(5'd1, 5'd8)); tick();
      void'(pop_exp());
      s = i_add(5'd2, 5'd8, 5'd3);
      s.flush = 1'b1;
      apply(s);
      total_cnt++;
      if ({PCWrite, IFIDWrite} !== 2'b11)
         $display("FAIL flush_wins got=%b want=11", {PCWrite, IFIDWrite});
      else pass_cnt++;
      tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want || {ExRegWrite, ExMemRead} !== 2'b00)
         $display("FAIL flush_bubble got=%h want=%h", got, want);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      exp_t got, want;
      in_t s;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: s = i_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            1: s = i_add(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            default: s = i_addi(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
         endcase
         s.regdest = 2'($urandom_range(0, 3));
         s.flush = ($urandom_range(0, 7) == 0);
         apply(s);
         total_cnt++;
         if (PCWrite !== m_pc_exp) $display("FAIL b2b_pcwrite[%0d] got=%b want=%b", i, PCWrite, m_pc_exp);
         else pass_cnt++;
         tick();
         got = sample(); want = pop_exp(); total_cnt++;
         if (got !== want) $display("FAIL b2b_bundle[%0d] got=%h want=%h", i, got, want); else pass_cnt++;
      end
   endtask

`ifdef MULT_STALL_EN
   task automatic test_mult_hold();
      exp_t got, want;
      apply(i_mul(5'd1, 5'd2, 5'd3)); tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want) $display("FAIL mul_capture got=%h want=%h", got, want); else pass_cnt++;
      for (int c = 0; c < 3; c++) begin
         apply(i_add(5'd4, 5'd5, 5'd6));
         total_cnt++;
         if ({ExHold, PCWrite, IFIDWrite} !== 3'b100)
            $display("FAIL mul_hold[%0d] got=%b want=100", c, {ExHold, PCWrite, IFIDWrite});
         else pass_cnt++;
         tick();
         got = sample(); want = pop_exp(); total_cnt++;
         if (got !== want || ExAluOp !== 5'b01100)
            $display("FAIL mul_stable[%0d] got=%h want=%h", c, got, want);
         else pass_cnt++;
      end
      apply(i_add(5'd4, 5'd5, 5'd6));
      total_cnt++;
      if ({ExHold, PCWrite} !== 2'b01)
         $display("FAIL mul_release got=%b want=01", {ExHold, PCWrite});
      else pass_cnt++;
      tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want || ExWriteReg !== 5'd6)
         $display("FAIL mul_next_capture got=%h want=%h", got, want);
      else pass_cnt++;
      apply(i_mul(5'd1, 5'd2, 5'd3)); tick();
      void'(pop_exp());
      apply(i_add(5'd4, 5'd5, 5'd7)); tick();
      void'(pop_exp());
      Reset_n = 1'b0;
      #1;
      model_reset();
      total_cnt++;
      if ({ExHold, PCWrite, IFIDWrite} !== 3'b011)
         $display("FAIL mul_reset got=%b want=011", {ExHold, PCWrite, IFIDWrite});
      else pass_cnt++;
      @(posedge Clock);
      #1;
      Reset_n = 1'b1;
      apply(i_add(5'd4, 5'd5, 5'd9)); tick();
      got = sample(); want = pop_exp(); total_cnt++;
      if (got !== want || ExHold !== 1'b0)
         $display("FAIL mul_reset_run got=%h want=%h", got, want);
      else pass_cnt++;
   endtask
`endif

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      m_hold = 0;
      m_pc_exp = 1'b1;
      model = '0;
      Reset_n = 1'b0;
      test_reset();
      test_dest();
      test_load_use();
      test_load_use_negative();
      test_flush();
      test_back_to_back();
`ifdef MULT_STALL_EN
      test_mult_hold();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
